// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_pkg
// Description : Shared constants and state types for the camera DMA path.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_pkg;

    localparam logic [47:0] c_dst_mac         = 48'hADAD_ADAD_ADAD;
    localparam logic [47:0] c_src_mac         = 48'hACAC_ACAC_ACAC;
    localparam logic [1:0]  c_marker_last     = 2'b01;
    localparam logic [1:0]  c_axi_burst_incr  = 2'b01;
    localparam logic [1:0]  c_axi_resp_okay   = 2'b00;
    localparam logic [1:0]  c_axi_resp_slverr = 2'b10;

    typedef enum logic [1:0] {
        ING_IDLE = 2'd0,
        ING_WR   = 2'd1,
        ING_DROP = 2'd2
    } ing_state_t;

    typedef enum logic [2:0] {
        EGR_IDLE = 3'd0,
        EGR_AW   = 3'd1,
        EGR_W    = 3'd2,
        EGR_B    = 3'd3,
        EGR_DONE = 3'd4
    } egr_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word fall-through FIFO with level output.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 32,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [LW-1:0]    o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign w_push    = i_wr_en && (r_level != LW'(DEPTH));
    assign w_pop     = i_rd_en && (r_level != '0);
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/frame_dma_writer.sv
`default_nettype none
// ============================================================================
// Module      : frame_dma_writer
// Description : Filters camera packets into a FIFO and writes whole frames
//               into a ring of DDR buffers through an AXI4 write master.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_dma_writer
    import cam_pkg::*;
#(
    parameter int          AXI_DW        = 64,
    parameter int          BURST_ENTRIES = 1,
    parameter int          FRAME_BYTES   = 614400,
    parameter int          NUM_BUFS      = 2,
    parameter logic [31:0] BUF_BASE      = 32'h2BC0_0000,
    parameter logic [31:0] BUF_STRIDE    = 32'h0020_0000,
    parameter int          FIFO_DEPTH    = 32,
    parameter int          ALF_MARGIN    = 4,
    parameter logic [47:0] DST_MAC       = c_dst_mac,
    parameter logic [47:0] SRC_MAC       = c_src_mac
) (
    input  logic                clk,
    input  logic                srst,
    input  logic [519:0]        pktin_data,
    input  logic                pktin_en,
    input  logic                pkt_in_md_en,
    output logic                pkt_data_alf,
    input  logic                ddr_write_start_valid,
    output logic                ddr_write_start_ready,
    output logic                ddr_write_finish_valid,
    input  logic                ddr_write_finish_ready,
    output logic [2:0]          ddr_write_finish_buf,
    output logic [31:0]         M_AXI_AWADDR,
    output logic [7:0]          M_AXI_AWLEN,
    output logic [2:0]          M_AXI_AWSIZE,
    output logic [1:0]          M_AXI_AWBURST,
    output logic [3:0]          M_AXI_AWCACHE,
    output logic [2:0]          M_AXI_AWPROT,
    output logic                M_AXI_AWVALID,
    input  logic                M_AXI_AWREADY,
    output logic [AXI_DW-1:0]   M_AXI_WDATA,
    output logic [AXI_DW/8-1:0] M_AXI_WSTRB,
    output logic                M_AXI_WLAST,
    output logic                M_AXI_WVALID,
    input  logic                M_AXI_WREADY,
    input  logic [1:0]          M_AXI_BRESP,
    input  logic                M_AXI_BVALID,
    output logic                M_AXI_BREADY,
    output logic [15:0]         drop_cnt,
    output logic [15:0]         bresp_err_cnt
);

    localparam int          c_slices      = 512 / AXI_DW;
    localparam int          c_beats       = BURST_ENTRIES * c_slices;
    localparam int          c_slice_w     = (c_slices > 1) ? $clog2(c_slices) : 1;
    localparam int          c_lvl_w       = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] c_burst_bytes = 32'(BURST_ENTRIES * 64);
    localparam logic [31:0] c_frame_bytes = 32'(FRAME_BYTES);

    if (c_beats > 256) begin : g_err_awlen
        $error("burst length exceeds 256 beats");
    end
    if ((4096 % (BURST_ENTRIES * 64)) != 0) begin : g_err_4k
        $error("burst size must divide 4096");
    end
    if ((FRAME_BYTES % (BURST_ENTRIES * 64)) != 0) begin : g_err_frame
        $error("frame size must be a multiple of the burst size");
    end
    if (NUM_BUFS < 1 || NUM_BUFS > 8) begin : g_err_bufs
        $error("NUM_BUFS out of range");
    end

    logic [c_lvl_w-1:0] w_level;
    logic [511:0]       w_fifo_rd_data;
    logic               w_fifo_rd;
    logic               r_fifo_wr;
    logic [511:0]       r_fifo_wdata;
    logic               w_unused_bits;

    sync_fifo #(.WIDTH(512), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .srst      (srst),
        .i_wr_en   (r_fifo_wr),
        .i_wr_data (r_fifo_wdata),
        .i_rd_en   (w_fifo_rd),
        .o_rd_data (w_fifo_rd_data),
        .o_level   (w_level)
    );

    assign w_unused_bits = &{1'b0, pktin_data[517:512]};
    assign pkt_data_alf  = (FIFO_DEPTH - int'(w_level)) < ALF_MARGIN;

    // ---------------- ingress ----------------
    ing_state_t r_ing_state, w_ing_next;
    logic       w_push, w_drop, w_beat_last, w_hdr_match, w_full_eff;

    assign w_beat_last = pktin_en && pkt_in_md_en && (pktin_data[519:518] == c_marker_last);
    assign w_hdr_match = (pktin_data[511:464] == DST_MAC) && (pktin_data[463:416] == SRC_MAC);
    // A write still in the pipeline register already owns a FIFO slot.
    assign w_full_eff  = (int'(w_level) + int'(r_fifo_wr)) >= FIFO_DEPTH;

    always_comb begin
        w_ing_next = r_ing_state;
        w_push     = 1'b0;
        w_drop     = 1'b0;
        case (r_ing_state)
            ING_IDLE: if (pktin_en && w_hdr_match) w_ing_next = ING_WR;
            ING_WR: begin
                if (pktin_en) begin
                    if (w_full_eff) begin
                        w_drop     = 1'b1;
                        w_ing_next = w_beat_last ? ING_IDLE : ING_DROP;
                    end else begin
                        w_push = 1'b1;
                        if (w_beat_last) w_ing_next = ING_IDLE;
                    end
                end
            end
            ING_DROP: if (w_beat_last) w_ing_next = ING_IDLE;
            default:  w_ing_next = ING_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_ing_state  <= ING_IDLE;
            r_fifo_wr    <= 1'b0;
            r_fifo_wdata <= '0;
            drop_cnt     <= '0;
        end else begin
            r_ing_state  <= w_ing_next;
            r_fifo_wr    <= w_push;
            r_fifo_wdata <= pktin_data[511:0];
            if (w_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // ---------------- egress ----------------
    egr_state_t           r_egr_state, w_egr_next;
    logic                 r_armed;
    logic [2:0]           r_buf_idx;
    logic [31:0]          r_buf_base;
    logic [31:0]          r_offset;
    logic [7:0]           r_beat;
    logic [c_slice_w-1:0] w_slice;
    logic                 w_last_slice, w_last_beat;

    if (c_slices > 1) begin : g_slice
        assign w_slice = r_beat[c_slice_w-1:0];
    end else begin : g_slice_one
        assign w_slice = '0;
    end

    assign w_last_slice = (w_slice == c_slice_w'(c_slices - 1));
    assign w_last_beat  = (r_beat == 8'(c_beats - 1));

    assign M_AXI_AWADDR  = r_buf_base + r_offset;
    assign M_AXI_AWLEN   = 8'(c_beats - 1);
    assign M_AXI_AWSIZE  = 3'($clog2(AXI_DW / 8));
    assign M_AXI_AWBURST = c_axi_burst_incr;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_WDATA   = w_fifo_rd_data[w_slice*AXI_DW +: AXI_DW];
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = (r_egr_state == EGR_W) && w_last_beat;

    assign ddr_write_start_ready = !srst && (r_egr_state == EGR_IDLE) && !r_armed;
    assign ddr_write_finish_buf  = r_buf_idx;

    always_comb begin
        w_egr_next             = r_egr_state;
        M_AXI_AWVALID          = 1'b0;
        M_AXI_WVALID           = 1'b0;
        M_AXI_BREADY           = 1'b0;
        ddr_write_finish_valid = 1'b0;
        w_fifo_rd              = 1'b0;
        case (r_egr_state)
            EGR_IDLE: if (r_armed && int'(w_level) >= BURST_ENTRIES) w_egr_next = EGR_AW;
            EGR_AW: begin
                M_AXI_AWVALID = 1'b1;
                if (M_AXI_AWREADY) w_egr_next = EGR_W;
            end
            EGR_W: begin
                M_AXI_WVALID = 1'b1;
                if (M_AXI_WREADY) begin
                    w_fifo_rd = w_last_slice;
                    if (w_last_beat) w_egr_next = EGR_B;
                end
            end
            EGR_B: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) begin
                    w_egr_next = (r_offset + c_burst_bytes == c_frame_bytes) ? EGR_DONE : EGR_IDLE;
                end
            end
            EGR_DONE: begin
                ddr_write_finish_valid = 1'b1;
                if (ddr_write_finish_ready) w_egr_next = EGR_IDLE;
            end
            default: w_egr_next = EGR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_egr_state   <= EGR_IDLE;
            r_armed       <= 1'b0;
            r_buf_idx     <= '0;
            r_buf_base    <= BUF_BASE;
            r_offset      <= '0;
            r_beat        <= '0;
            bresp_err_cnt <= '0;
        end else begin
            r_egr_state <= w_egr_next;
            if (ddr_write_start_valid && ddr_write_start_ready) r_armed <= 1'b1;
            if (r_egr_state == EGR_AW) r_beat <= '0;
            if (r_egr_state == EGR_W && M_AXI_WREADY) r_beat <= r_beat + 1'b1;
            if (r_egr_state == EGR_B && M_AXI_BVALID) begin
                r_offset <= r_offset + c_burst_bytes;
                if (M_AXI_BRESP != c_axi_resp_okay && bresp_err_cnt != 16'hFFFF) begin
                    bresp_err_cnt <= bresp_err_cnt + 1'b1;
                end
            end
            if (r_egr_state == EGR_DONE && ddr_write_finish_ready) begin
                r_offset <= '0;
                r_armed  <= 1'b0;
                if (r_buf_idx == 3'(NUM_BUFS - 1)) begin
                    r_buf_idx  <= '0;
                    r_buf_base <= BUF_BASE;
                end else begin
                    r_buf_idx  <= r_buf_idx + 1'b1;
                    r_buf_base <= r_buf_base + BUF_STRIDE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_dma_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_dma_writer
// Description : Randomized self-checking bench for frame_dma_writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_dma_writer;

    localparam int          DW     = 64;
    localparam int          BE     = 1;
    localparam int          FB     = 256;
    localparam int          NB     = 2;
    localparam int          FD     = 4;
    localparam int          AM     = 2;
    localparam logic [31:0] BASE   = 32'h2BC0_0000;
    localparam logic [31:0] STRIDE = 32'h0020_0000;
    localparam logic [47:0] DST    = 48'hADAD_ADAD_ADAD;
    localparam logic [47:0] SRC    = 48'hACAC_ACAC_ACAC;
    localparam int          SLICES = 512 / DW;
    localparam int          BEATS  = BE * SLICES;
    localparam int          BPF    = FB / (BE * 64);

    logic          clk = 1'b0;
    logic          srst;
    logic [519:0]  pktin_data;
    logic          pktin_en, pkt_in_md_en, pkt_data_alf;
    logic          start_valid, start_ready, finish_valid, finish_ready;
    logic [2:0]    finish_buf;
    logic [31:0]   awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize, awprot;
    logic [1:0]    awburst, bresp;
    logic [3:0]    awcache;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic [15:0]   drop_cnt, bresp_err_cnt;

    always #5 clk = ~clk;

    frame_dma_writer #(
        .AXI_DW(DW), .BURST_ENTRIES(BE), .FRAME_BYTES(FB), .NUM_BUFS(NB),
        .BUF_BASE(BASE), .BUF_STRIDE(STRIDE), .FIFO_DEPTH(FD), .ALF_MARGIN(AM),
        .DST_MAC(DST), .SRC_MAC(SRC)
    ) dut (
        .clk(clk), .srst(srst),
        .pktin_data(pktin_data), .pktin_en(pktin_en), .pkt_in_md_en(pkt_in_md_en),
        .pkt_data_alf(pkt_data_alf),
        .ddr_write_start_valid(start_valid), .ddr_write_start_ready(start_ready),
        .ddr_write_finish_valid(finish_valid), .ddr_write_finish_ready(finish_ready),
        .ddr_write_finish_buf(finish_buf),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWCACHE(awcache), .M_AXI_AWPROT(awprot),
        .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .drop_cnt(drop_cnt), .bresp_err_cnt(bresp_err_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state: payload entries expected in DDR order plus handshake counters.
    logic [511:0] exp_q[$];
    int  aw_cnt = 0, wlast_cnt = 0, bhs_cnt = 0, fin_cnt = 0, outstanding = 0;
    int  wbeat = 0, ss_viol = 0;
    bit  mon_en = 1'b0;
    bit  arm_en = 1'b0;

    function automatic logic [31:0] exp_addr(input int k);
        int frame, bufi;
        frame = k / BPF;
        bufi  = frame % NB;
        return BASE + 32'(bufi) * STRIDE + 32'((k % BPF) * BE * 64);
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin : monitor
        bit aw_wait = 1'b0;
        logic [511:0] ent;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (aw_wait) check_eq("aw_hold", awvalid, 1'b1);
                aw_wait = awvalid && !awready;
                if (awvalid && awready) begin
                    check_eq("aw_outstanding", outstanding, 0);
                    check_eq("awaddr", awaddr, exp_addr(aw_cnt));
                    check_eq("awlen", awlen, BEATS - 1);
                    check_eq("awsize", awsize, $clog2(DW / 8));
                    check_eq("awburst", awburst, 2'b01);
                    aw_cnt++;
                    outstanding++;
                end
                if (wvalid && wready) begin
                    check_eq("w_have_entry", exp_q.size() > 0, 1'b1);
                    check_eq("wstrb", wstrb, {(DW/8){1'b1}});
                    if (exp_q.size() > 0) begin
                        ent = exp_q[0];
                        check_eq("wdata", wdata, ent[(wbeat % SLICES)*DW +: DW]);
                        check_eq("wlast", wlast, wbeat == BEATS - 1);
                        if ((wbeat % SLICES) == SLICES - 1) void'(exp_q.pop_front());
                    end
                    if (wbeat == BEATS - 1) begin
                        wbeat = 0;
                        wlast_cnt++;
                    end else begin
                        wbeat++;
                    end
                end
                if (bvalid && bready) begin
                    bhs_cnt++;
                    outstanding--;
                end
                if (finish_valid && finish_ready) begin
                    check_eq("finish_buf", finish_buf, fin_cnt % NB);
                    fin_cnt++;
                end
                if (start_ready && finish_valid) ss_viol++;
            end
        end
    end

    initial begin : b_driver
        int b_issued = 0;
        bvalid = 1'b0;
        bresp  = 2'b00;
        forever begin
            @(posedge clk); #1;
            if (srst) begin
                bvalid = 1'b0;
            end else if (bvalid) begin
                if (bhs_cnt == b_issued) bvalid = 1'b0;
            end else if (wlast_cnt > b_issued) begin
                bvalid = 1'b1;
                bresp  = (b_issued == 1) ? 2'b10 : 2'b00;
                b_issued++;
            end
        end
    end

    initial begin : ready_rand
        awready = 1'b0; wready = 1'b0; finish_ready = 1'b0; start_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            awready      = 1'($urandom % 2);
            wready       = 1'($urandom % 2);
            finish_ready = 1'($urandom % 2);
            start_valid  = arm_en && 1'($urandom % 2);
        end
    end

    task automatic drive_beat(input logic [511:0] p, input logic [1:0] mk, input logic md);
        pktin_data   = {mk, 6'b0, p};
        pktin_en     = 1'b1;
        pkt_in_md_en = md;
        @(posedge clk); #1;
        pktin_en     = 1'b0;
        pkt_in_md_en = 1'b0;
    endtask

    task automatic wait_room();
        for (int k = 0; k < 2000 && pkt_data_alf; k++) begin
            @(posedge clk); #1;
        end
        if (pkt_data_alf) check_eq("alf_timeout", pkt_data_alf, 1'b0);
    endtask

    // n payload beats; the model expects the first n_store of them in DDR.
    task automatic send_pkt(input int n, input bit match, input bit paced, input int n_store);
        logic [511:0] hdr, p;
        hdr = rand512();
        hdr[511:464] = match ? DST : 48'h0;
        hdr[463:416] = SRC;
        drive_beat(hdr, 2'b00, 1'b0);
        for (int i = 0; i < n; i++) begin
            p = rand512();
            if (i < n_store) exp_q.push_back(p);
            if (paced) wait_room();
            drive_beat(p, (i == n - 1) ? 2'b01 : 2'b00, i == n - 1);
            if (paced) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 4000 && (exp_q.size() != 0 || outstanding != 0); k++) begin
            @(posedge clk); #1;
        end
        check_eq("drain_queue", exp_q.size(), 0);
        check_eq("drain_outstanding", outstanding, 0);
    endtask

    task automatic wait_fin(input int n);
        for (int k = 0; k < 2000 && fin_cnt < n; k++) begin
            @(posedge clk); #1;
        end
        check_eq("finish_count", fin_cnt, n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_start_ready"}, start_ready, 1'b0);
        check_eq({tag, "_awvalid"}, awvalid, 1'b0);
        check_eq({tag, "_wvalid"}, wvalid, 1'b0);
        check_eq({tag, "_wlast"}, wlast, 1'b0);
        check_eq({tag, "_bready"}, bready, 1'b0);
        check_eq({tag, "_finish_valid"}, finish_valid, 1'b0);
        check_eq({tag, "_drop_cnt"}, drop_cnt, 16'd0);
        check_eq({tag, "_bresp_err"}, bresp_err_cnt, 16'd0);
        check_eq({tag, "_alf"}, pkt_data_alf, 1'b0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int aw0, k;
        srst = 1'b1; pktin_data = '0; pktin_en = 1'b0; pkt_in_md_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        srst   = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;
        check_eq("idle_start_ready", start_ready, 1'b1);

        // Egress unarmed: only the FIFO depth worth of beats survives, one drop.
        send_pkt(8, 1'b1, 1'b0, FD);
        repeat (5) @(posedge clk);
        #1;
        check_eq("overflow_drop_cnt", drop_cnt, 16'd1);
        check_eq("full_alf", pkt_data_alf, 1'b1);
        check_eq("unarmed_no_aw", aw_cnt, 0);

        arm_en = 1'b1;
        wait_drain();
        wait_fin(1);

        send_pkt(10, 1'b1, 1'b1, 10);
        wait_drain();

        aw0 = aw_cnt;
        send_pkt(3, 1'b0, 1'b1, 0);
        repeat (40) @(posedge clk);
        #1;
        check_eq("nomatch_no_aw", aw_cnt, aw0);
        check_eq("nomatch_drop_cnt", drop_cnt, 16'd1);

        send_pkt(2, 1'b1, 1'b1, 2);
        wait_drain();
        wait_fin(4);
        check_eq("total_bursts", aw_cnt, 16);
        check_eq("bresp_err_cnt", bresp_err_cnt, 16'd1);
        check_eq("start_finish_overlap", ss_viol, 0);

        // Reset in the middle of a W burst.
        fork
            send_pkt(4, 1'b1, 1'b1, 4);
        join_none
        for (k = 0; k < 2000 && !(wvalid && wbeat >= 3); k++) begin
            @(posedge clk); #1;
        end
        check_eq("mid_w_reached", wvalid && wbeat >= 3, 1'b1);
        arm_en = 1'b0;
        mon_en = 1'b0;
        srst   = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midw_reset");
        srst = 1'b0;
        @(posedge clk); #1;
        check_eq("post_reset_start_ready", start_ready, 1'b1);
        check_eq("post_reset_awvalid", awvalid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
